axi_burst_loader: RTL and testbench
===================================

AXI_BURST_LOADER -- requirements
Module: axi_burst_loader

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 128, AXI beat width; power of two, at least 32.
REQ-003 SHALL have parameter C_M_AXI_ID_WIDTH, default 1, AXI ID width.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 256, maximum beats per burst, 1..256.
REQ-005 SHALL have parameter INOUT_WIDTH, default 256, RAM word width; integer power-of-two multiple R of C_M_AXI_DATA_WIDTH.
REQ-006 SHALL have parameter RAM_ADDR_WIDTH, default 19, RAM word-address width.
REQ-007 SHALL have the following ports, clock and reset first:
- M_AXI_ACLK  in  1  sole clock, rising edge; the block has one clock.
- M_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle transfer request.
- src_addr  in  C_M_AXI_ADDR_WIDTH  byte address, beat-aligned.
- num_beats  in  24  transfer length in AXI beats.
- dst_addr  in  RAM_ADDR_WIDTH  first RAM word address.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky error flag.
- M_AXI_ARID / ARADDR / ARLEN(8) / ARSIZE(3) / ARBURST(2) / ARVALID  out  AXI4 read address.
- M_AXI_ARREADY  in  1.
- M_AXI_RID / RDATA / RRESP(2) / RLAST / RVALID  in  AXI4 read data.
- M_AXI_RREADY  out  1.
- ram_we  out  1; ram_addr  out  RAM_ADDR_WIDTH; ram_wdata  out  INOUT_WIDTH.

Function
REQ-008 SHALL implement states IDLE, ADDR, DATA, DONE.
REQ-009 SHALL, in IDLE with start=1, latch src_addr, num_beats and dst_addr, clear error, and enter ADDR; if num_beats=0, it SHALL enter DONE instead and issue no AR.
REQ-010 SHALL ignore start outside IDLE.
REQ-011 SHALL assert busy in every state except IDLE.
REQ-012 SHALL compute each burst length as min(remaining beats, MAX_BURST_LEN, beats left before the next 4 KB boundary), and drive ARLEN = length-1.
REQ-013 SHALL drive ARSIZE = log2(C_M_AXI_DATA_WIDTH/8), ARBURST = 2'b01 (INCR), and ARID = 0.
REQ-014 SHALL hold ARVALID and ARADDR stable in ADDR until ARREADY, then enter DATA; at most one burst is outstanding.
REQ-015 SHALL drive RREADY=1 only in DATA; a beat is accepted when RVALID & RREADY.
REQ-016 SHALL pack accepted beats LSB-first: beat k of each R-beat group goes to lanes [k*DW +: DW].
REQ-017 SHALL, on acceptance of the R-th beat of a group, register ram_wdata and assert ram_we for exactly one cycle on the next clock, at ram_addr = dst_addr + group index.
REQ-018 SHALL, when the transfer's final beat completes a partial group, write that word with unfilled lanes zero.
REQ-019 SHALL, after the last beat of a burst, return to ADDR if beats remain and no error is set; otherwise go to DONE.
REQ-020 SHALL, in DONE, assert done for one cycle and return to IDLE; the final ram_we coincides with done.
REQ-021 SHALL set error on any accepted beat with RRESP != 0, or with RLAST mismatching the expected last beat.
REQ-022 SHALL keep error set until the next accepted start.
REQ-023 SHALL, on error, drain the current burst (keeping RREADY=1 until its expected beat count), issue no further AR, and still pulse done.
REQ-024 SHALL treat an early RLAST as the end of the burst.

Reset
REQ-025 SHALL, while M_AXI_ARESETN=0, hold state IDLE and drive busy, done, error, ARVALID, RREADY and ram_we to 0, and ARADDR, ARLEN, ram_addr, ram_wdata and all counters to 0.
REQ-026 SHALL, on reset asserted mid-transfer, abandon the transfer immediately, with no done pulse and no further ram_we.

Verification
REQ-027 SHALL cover this scenario (DW=128, INOUT=256): start, src=0x10000000, num_beats=8, dst=0x10 -> one AR with ARLEN=7; 4 ram_we at addresses 0x10..0x13; done coincides with the 4th write.
REQ-028 SHALL cover this scenario: src=0x00000F80, num_beats=16 -> two ARs: 0xF80 with ARLEN=7, then 0x1000 with ARLEN=7.
REQ-029 SHALL cover this scenario: num_beats=600 from 0x0 -> ARLEN sequence 255, 255, 87; 300 writes.
REQ-030 SHALL cover this scenario: num_beats=3 -> 2 writes; the second write has upper 128 bits = 0.
REQ-031 SHALL cover this scenario: num_beats=512, RRESP=2'b10 on beat 3 of burst 1 -> error=1; the 256 beats of burst 1 are accepted; no second AR; done pulses; error clears on the next start.
REQ-032 SHALL cover these scenarios: random ARREADY/RVALID stalls, and M_AXI_ARESETN low during DATA -> outputs at reset values within the same cycle, no done; num_beats=0 -> done one cycle after start with no AR.

Source files
------------

// File: rtl/axi_burst_loader_if.sv
// AXI4 read-channel bundle (AR + R) between the loader
// and a memory-side slave.
interface axi_burst_loader_if #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_M_AXI_ID_WIDTH   = 1
);
    logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID;
    logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [7:0]                    M_AXI_ARLEN;
    logic [2:0]                    M_AXI_ARSIZE;
    logic [1:0]                    M_AXI_ARBURST;
    logic                          M_AXI_ARVALID;
    logic                          M_AXI_ARREADY;
    logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID;
    logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]                    M_AXI_RRESP;
    logic                          M_AXI_RLAST;
    logic                          M_AXI_RVALID;
    logic                          M_AXI_RREADY;

    modport master (
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN,
        output M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP,
        input  M_AXI_RLAST, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN,
        input  M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP,
        output M_AXI_RLAST, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi_burst_loader.sv
// AXI4 burst reader that packs R beats into wide RAM words.
// Bursts are split at MAX_BURST_LEN and at 4 KB boundaries.
module axi_burst_loader #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int MAX_BURST_LEN      = 256,
    parameter int INOUT_WIDTH        = 256,
    parameter int RAM_ADDR_WIDTH     = 19
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] src_addr,
    input  logic [23:0]                   num_beats,
    input  logic [RAM_ADDR_WIDTH-1:0]     dst_addr,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    axi_burst_loader_if.master            m_axi,
    output logic                          ram_we,
    output logic [RAM_ADDR_WIDTH-1:0]     ram_addr,
    output logic [INOUT_WIDTH-1:0]        ram_wdata
);
    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int DW    = C_M_AXI_DATA_WIDTH;
    localparam int R     = INOUT_WIDTH / DW;
    localparam int LW    = (R > 1) ? $clog2(R) : 1;
    localparam int SIZE  = $clog2(DW / 8);
    localparam int BYTES = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE, S_ADDR, S_DATA, S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [AW-1:0]             r_addr;
    logic [23:0]               r_remaining;
    logic [RAM_ADDR_WIDTH-1:0] r_dst;
    logic [RAM_ADDR_WIDTH-1:0] r_group;
    logic [8:0]                r_burst_len;
    logic [8:0]                r_beat_cnt;
    logic [LW-1:0]             r_lane;
    logic [INOUT_WIDTH-1:0]    r_pack;
    logic                      r_error;
    logic                      r_ram_we;
    logic [RAM_ADDR_WIDTH-1:0] r_ram_addr;
    logic [INOUT_WIDTH-1:0]    r_ram_wdata;

    logic [12:0]            w_4k_bytes;
    logic [23:0]            w_4k_beats;
    logic [23:0]            w_len24;
    logic [8:0]             w_len;
    logic                   w_beat;
    logic                   w_last_exp;
    logic                   w_bad;
    logic                   w_burst_end;
    logic                   w_xfer_last;
    logic                   w_flush;
    logic [INOUT_WIDTH-1:0] w_word;

    // Burst length: min(remaining, MAX_BURST_LEN, beats to next 4 KB page).
    always_comb begin
        w_4k_bytes = 13'h1000 - {1'b0, r_addr[11:0]};
        w_4k_beats = 24'(w_4k_bytes >> SIZE);
        w_len24    = r_remaining;
        if (w_len24 > 24'(MAX_BURST_LEN)) w_len24 = 24'(MAX_BURST_LEN);
        if (w_len24 > w_4k_beats)         w_len24 = w_4k_beats;
        w_len = w_len24[8:0];
    end

    assign w_beat      = (r_state == S_DATA) & m_axi.M_AXI_RVALID;
    assign w_last_exp  = ((r_beat_cnt + 9'd1) == r_burst_len);
    assign w_bad       = w_beat & ((m_axi.M_AXI_RRESP != 2'b00) |
                                   (m_axi.M_AXI_RLAST != w_last_exp));
    assign w_burst_end = w_beat & (w_last_exp | m_axi.M_AXI_RLAST);
    assign w_xfer_last = (r_remaining == 24'd1);
    assign w_flush     = w_beat & ((r_lane == LW'(R - 1)) | w_xfer_last);

    // Merge the incoming beat into its lane; higher lanes are still zero.
    always_comb begin
        w_word = r_pack;
        w_word[r_lane*DW +: DW] = m_axi.M_AXI_RDATA;
    end

    // Next-state logic; an error or the final beat ends the transfer.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = (num_beats == 24'd0) ? S_DONE : S_ADDR;
            end
            S_ADDR: begin
                if (m_axi.M_AXI_ARREADY) w_next = S_DATA;
            end
            S_DATA: begin
                if (w_burst_end)
                    w_next = (!w_xfer_last && !r_error && !w_bad) ? S_ADDR : S_DONE;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) r_state <= S_IDLE;
        else                r_state <= w_next;
    end

    // Transfer bookkeeping, beat packing and RAM write port.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_dst       <= '0;
            r_group     <= '0;
            r_burst_len <= '0;
            r_beat_cnt  <= '0;
            r_lane      <= '0;
            r_pack      <= '0;
            r_error     <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_we <= 1'b0;
            if (r_state == S_IDLE && start) begin
                r_addr      <= src_addr;
                r_remaining <= num_beats;
                r_dst       <= dst_addr;
                r_group     <= '0;
                r_lane      <= '0;
                r_pack      <= '0;
                r_error     <= 1'b0;
            end
            if (r_state == S_ADDR && m_axi.M_AXI_ARREADY) begin
                r_burst_len <= w_len;
                r_beat_cnt  <= '0;
            end
            if (w_beat) begin
                r_beat_cnt  <= r_beat_cnt + 9'd1;
                r_remaining <= r_remaining - 24'd1;
                r_addr      <= r_addr + AW'(BYTES);
                if (w_bad) r_error <= 1'b1;
                if (w_flush) begin
                    r_ram_we    <= 1'b1;
                    r_ram_wdata <= w_word;
                    r_ram_addr  <= r_dst + r_group;
                    r_group     <= r_group + 1'b1;
                    r_lane      <= '0;
                    r_pack      <= '0;
                end else begin
                    r_pack <= w_word;
                    r_lane <= r_lane + 1'b1;
                end
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign error     = r_error;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

    assign m_axi.M_AXI_ARID    = '0;
    assign m_axi.M_AXI_ARSIZE  = 3'(SIZE);
    assign m_axi.M_AXI_ARBURST = 2'b01;
    assign m_axi.M_AXI_ARVALID = (r_state == S_ADDR);
    assign m_axi.M_AXI_ARADDR  = (r_state == S_ADDR) ? r_addr : '0;
    assign m_axi.M_AXI_ARLEN   = (r_state == S_ADDR) ? 8'(w_len - 9'd1) : 8'd0;
    assign m_axi.M_AXI_RREADY  = (r_state == S_DATA);
endmodule

// File: tb/tb_axi_burst_loader.sv
// Directed bench for axi_burst_loader with a small AXI
// read slave, a RAM-write monitor and hand-computed vectors.
module tb_axi_burst_loader;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [31:0]  src_addr;
    logic [23:0]  num_beats;
    logic [18:0]  dst_addr;
    logic         busy, done, error;
    logic         ram_we;
    logic [18:0]  ram_addr;
    logic [255:0] ram_wdata;

    int total = 0;
    int bad   = 0;

    logic [255:0] we_data[$];
    logic [18:0]  we_addr[$];
    logic [31:0]  ar_addr[$];
    int           ar_len[$];
    logic [2:0]   last_size;
    logic [1:0]   last_burst;
    logic         last_id;
    int           done_cnt;
    logic         done_we;
    int           acc;
    int           beat_idx;
    bit           stall;
    int           err_beat;

    axi_burst_loader_if #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(128),
        .C_M_AXI_ID_WIDTH(1)
    ) axi ();

    axi_burst_loader #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(128),
        .C_M_AXI_ID_WIDTH(1),
        .MAX_BURST_LEN(256),
        .INOUT_WIDTH(256),
        .RAM_ADDR_WIDTH(19)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESETN(rst_n),
        .start(start),
        .src_addr(src_addr),
        .num_beats(num_beats),
        .dst_addr(dst_addr),
        .busy(busy),
        .done(done),
        .error(error),
        .m_axi(axi.master),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] bd(input int idx);
        logic [31:0] v;
        v = 32'(idx);
        return {v, v ^ 32'h5A5A5A5A, ~v, v + 32'h100};
    endfunction

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // AXI read slave: accepts AR, then returns ARLEN+1 beats.
    initial begin
        int n;
        axi.M_AXI_ARREADY = 1'b0;
        axi.M_AXI_RVALID  = 1'b0;
        axi.M_AXI_RLAST   = 1'b0;
        axi.M_AXI_RDATA   = '0;
        axi.M_AXI_RRESP   = 2'b00;
        axi.M_AXI_RID     = '0;
        forever begin
            @(negedge clk);
            if (rst_n && axi.M_AXI_ARVALID &&
                !(stall && $urandom_range(0, 1) == 0)) begin
                ar_addr.push_back(axi.M_AXI_ARADDR);
                ar_len.push_back(int'(axi.M_AXI_ARLEN));
                last_size  = axi.M_AXI_ARSIZE;
                last_burst = axi.M_AXI_ARBURST;
                last_id    = axi.M_AXI_ARID;
                n = int'(axi.M_AXI_ARLEN) + 1;
                axi.M_AXI_ARREADY = 1'b1;
                @(negedge clk);
                axi.M_AXI_ARREADY = 1'b0;
                for (int k = 0; k < n; k++) begin
                    while (rst_n && stall && $urandom_range(0, 2) == 0) begin
                        axi.M_AXI_RVALID = 1'b0;
                        @(negedge clk);
                    end
                    if (!rst_n) break;
                    axi.M_AXI_RVALID = 1'b1;
                    axi.M_AXI_RDATA  = bd(beat_idx);
                    axi.M_AXI_RRESP  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
                    axi.M_AXI_RLAST  = (k == n - 1);
                    @(negedge clk);
                    beat_idx++;
                    if (!rst_n) break;
                end
                axi.M_AXI_RVALID = 1'b0;
                axi.M_AXI_RLAST  = 1'b0;
                axi.M_AXI_RRESP  = 2'b00;
            end
        end
    end

    // Monitor: beat handshakes at the edge, RAM writes and done after it.
    always @(posedge clk) begin
        if (rst_n && axi.M_AXI_RVALID && axi.M_AXI_RREADY) acc++;
        #1;
        if (ram_we) begin
            we_addr.push_back(ram_addr);
            we_data.push_back(ram_wdata);
        end
        if (done) begin
            done_cnt++;
            done_we = ram_we;
        end
    end

    task automatic clr();
        we_addr.delete();
        we_data.delete();
        ar_addr.delete();
        ar_len.delete();
        done_cnt = 0;
        done_we  = 1'b0;
        acc      = 0;
        beat_idx = 0;
    endtask

    task automatic run(input logic [31:0] src, input logic [23:0] nb,
                       input logic [18:0] dst, input bit stl, input int eb);
        clr();
        stall    = stl;
        err_beat = eb;
        @(negedge clk);
        src_addr  = src;
        num_beats = nb;
        dst_addr  = dst;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 8000 && done_cnt == 0; c++) @(negedge clk);
        chk("done_seen", 256'(done_cnt > 0), 256'(1));
        repeat (3) @(negedge clk);
        chk("done_once", 256'(done_cnt), 256'(1));
    endtask

    task automatic chk_words(input int n, input logic [18:0] dst,
                             input int nb);
        logic [255:0] exp;
        chk("we_cnt", 256'(we_addr.size()), 256'(n));
        for (int g = 0; g < n && g < we_addr.size(); g++) begin
            chk("we_addr", 256'(we_addr[g]), 256'(19'(dst + 19'(g))));
            exp = {(2 * g + 1 < nb) ? bd(2 * g + 1) : 128'h0, bd(2 * g)};
            chk("we_data", we_data[g], exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        src_addr  = '0;
        num_beats = '0;
        dst_addr  = '0;
        stall     = 1'b0;
        err_beat  = -1;
        clr();
        repeat (3) @(negedge clk);
        chk("rst_busy",   256'(busy), 256'(0));
        chk("rst_done",   256'(done), 256'(0));
        chk("rst_err",    256'(error), 256'(0));
        chk("rst_arvld",  256'(axi.M_AXI_ARVALID), 256'(0));
        chk("rst_rrdy",   256'(axi.M_AXI_RREADY), 256'(0));
        chk("rst_we",     256'(ram_we), 256'(0));
        chk("rst_araddr", 256'(axi.M_AXI_ARADDR), 256'(0));
        chk("rst_arlen",  256'(axi.M_AXI_ARLEN), 256'(0));
        chk("rst_raddr",  256'(ram_addr), 256'(0));
        chk("rst_wdata",  ram_wdata, 256'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single 8-beat burst
        run(32'h1000_0000, 24'd8, 19'h10, 1'b0, -1);
        chk("t1_ar_cnt",  256'(ar_addr.size()), 256'(1));
        if (ar_addr.size() > 0) begin
            chk("t1_araddr", 256'(ar_addr[0]), 256'(32'h1000_0000));
            chk("t1_arlen",  256'(ar_len[0]), 256'(7));
        end
        chk("t1_arsize",  256'(last_size), 256'(4));
        chk("t1_arburst", 256'(last_burst), 256'(1));
        chk("t1_arid",    256'(last_id), 256'(0));
        chk_words(4, 19'h10, 8);
        chk("t1_done_we", 256'(done_we), 256'(1));
        chk("t1_err",     256'(error), 256'(0));
        chk("t1_idle",    256'(busy), 256'(0));

        // 4 KB boundary split
        run(32'h0000_0F80, 24'd16, 19'h40, 1'b0, -1);
        chk("t2_ar_cnt", 256'(ar_addr.size()), 256'(2));
        if (ar_addr.size() > 1) begin
            chk("t2_araddr0", 256'(ar_addr[0]), 256'(32'hF80));
            chk("t2_arlen0",  256'(ar_len[0]), 256'(7));
            chk("t2_araddr1", 256'(ar_addr[1]), 256'(32'h1000));
            chk("t2_arlen1",  256'(ar_len[1]), 256'(7));
        end
        chk_words(8, 19'h40, 16);

        // MAX_BURST_LEN split, 600 beats
        run(32'h0, 24'd600, 19'h100, 1'b0, -1);
        chk("t3_ar_cnt", 256'(ar_addr.size()), 256'(3));
        if (ar_len.size() > 2) begin
            chk("t3_arlen0",  256'(ar_len[0]), 256'(255));
            chk("t3_arlen1",  256'(ar_len[1]), 256'(255));
            chk("t3_arlen2",  256'(ar_len[2]), 256'(87));
            chk("t3_araddr2", 256'(ar_addr[2]), 256'(32'h2000));
        end
        chk_words(300, 19'h100, 600);
        chk("t3_done_we", 256'(done_we), 256'(1));

        // partial final group
        run(32'h0000_0400, 24'd3, 19'h7, 1'b0, -1);
        chk_words(2, 19'h7, 3);
        if (we_data.size() > 1)
            chk("t4_upper0", 256'(we_data[1][255:128]), 256'(0));
        chk("t4_done_we", 256'(done_we), 256'(1));

        // SLVERR on beat 3 of burst 1: drain, no 2nd AR, sticky error
        run(32'h0, 24'd512, 19'h0, 1'b0, 3);
        chk("t5_err",    256'(error), 256'(1));
        chk("t5_ar_cnt", 256'(ar_addr.size()), 256'(1));
        chk("t5_acc",    256'(acc), 256'(256));
        run(32'h0000_0800, 24'd2, 19'h20, 1'b0, -1);
        chk("t5_err_clr", 256'(error), 256'(0));
        chk_words(1, 19'h20, 2);

        // random ARREADY/RVALID stalls
        run(32'h0000_0E00, 24'd40, 19'h200, 1'b1, -1);
        chk("t6_ar_cnt", 256'(ar_addr.size()), 256'(2));
        chk_words(20, 19'h200, 40);
        chk("t6_done_we", 256'(done_we), 256'(1));
        chk("t6_err",     256'(error), 256'(0));
        stall = 1'b0;

        // reset during DATA
        clr();
        @(negedge clk);
        src_addr  = 32'h0;
        num_beats = 24'd64;
        dst_addr  = 19'h300;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && acc < 10; c++) @(negedge clk);
        chk("t7_in_data", 256'(axi.M_AXI_RREADY), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("t7_busy",  256'(busy), 256'(0));
        chk("t7_rrdy",  256'(axi.M_AXI_RREADY), 256'(0));
        chk("t7_we",    256'(ram_we), 256'(0));
        chk("t7_raddr", 256'(ram_addr), 256'(0));
        chk("t7_wdata", ram_wdata, 256'(0));
        we_addr.delete();
        we_data.delete();
        done_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t7_no_done", 256'(done_cnt), 256'(0));
        chk("t7_no_we",   256'(we_addr.size()), 256'(0));
        chk("t7_idle",    256'(busy), 256'(0));

        // zero-length transfer
        clr();
        @(negedge clk);
        num_beats = 24'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t8_done", 256'(done), 256'(1));
        @(negedge clk);
        chk("t8_done_off", 256'(done), 256'(0));
        chk("t8_idle",     256'(busy), 256'(0));
        repeat (3) @(negedge clk);
        chk("t8_no_ar", 256'(ar_addr.size()), 256'(0));
        chk("t8_no_we", 256'(we_addr.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
